pipeline_hazard_sequencer: RTL and testbench

- Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between the ID and EX stages.
- Flushes IF/ID and ID/EX when a branch or jump resolves taken in EX.
- Tracks the multi-cycle HI/LO (mult/div) unit, stalls ID instructions that touch HI/LO while it is busy, and keeps saturating performance counters.

---
 rtl/pipeline_hazard_sequencer.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the five-stage pipeline.
// Resolves load-use hazards between ID and EX, flushes the front end on a
// taken branch/jump in EX, tracks the HI/LO (mult/div) unit busy window and
// keeps saturating stall/flush counters.
module pipeline_hazard_sequencer #(
  parameter int MDU_LAT = 4,   // busy cycles after a mult/div issues (2..15)
  parameter int CNT_W   = 16   // performance counter width
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             MdStart_ID,
  input  logic             HiLoAcc_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       RegDest_EX,
  input  logic             Taken_EX,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN    = 1'b0,
    MDBUSY = 1'b1
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MDU_LAT - 1);

  state_t           st_q, st_d;
  logic [3:0]       mdcnt_q, mdcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_hazard;
  logic md_hazard;
  logic stall_cycle;
  logic issue;

  // Hazard detection: a load in EX whose destination is read by the ID
  // instruction, or a HI/LO access while the mult/div unit is still busy.
  always_comb begin
    lu_hazard = MemRead_EX && (RegDest_EX != 5'd0) &&
                ((UsesRs_ID && (Rs_ID == RegDest_EX)) ||
                 (UsesRt_ID && (Rt_ID == RegDest_EX)));
    md_hazard = (st_q == MDBUSY) && HiLoAcc_ID;
    // A taken branch discards the ID instruction, so hazards do not stall.
    stall_cycle = Rst && !Taken_EX && (lu_hazard || md_hazard);
    issue       = MdStart_ID && !Taken_EX && !lu_hazard && !md_hazard;
  end

  // Priority decode of pipeline control: reset, flush, stall, run.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (!Rst) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (Taken_EX) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (lu_hazard || md_hazard) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  // Mult/div busy tracker; a taken branch never shortens the busy window
  // because the mult/div has already left ID.
  always_comb begin
    st_d    = st_q;
    mdcnt_d = mdcnt_q;
    case (st_q)
      RUN: begin
        if (issue) begin
          st_d    = MDBUSY;
          mdcnt_d = MD_LOAD;
        end
      end
      MDBUSY: begin
        if (mdcnt_q == 4'd1) begin
          st_d    = RUN;
          mdcnt_d = 4'd0;
        end else begin
          mdcnt_d = mdcnt_q - 4'd1;
        end
      end
      default: begin
        st_d    = RUN;
        mdcnt_d = 4'd0;
      end
    endcase
  end

  // Saturating performance counters; they hold at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_cycle && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (Taken_EX && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      st_q        <= RUN;
      mdcnt_q     <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      mdcnt_q     <= mdcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MdBusy     = (st_q == MDBUSY);
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer: directed scenarios,
// randomized traffic and counter saturation against a behavioural model.
module tb_pipeline_hazard_sequencer;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [4:0]       Rs_ID, Rt_ID, RegDest_EX;
  logic             UsesRs_ID, UsesRt_ID, MdStart_ID, HiLoAcc_ID;
  logic             MemRead_EX, Taken_EX;
  logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MdBusy;
  logic [CNT_W-1:0] StallCount, FlushCount;

  pipeline_hazard_sequencer #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Rs_ID      (Rs_ID),
    .Rt_ID      (Rt_ID),
    .UsesRs_ID  (UsesRs_ID),
    .UsesRt_ID  (UsesRt_ID),
    .MdStart_ID (MdStart_ID),
    .HiLoAcc_ID (HiLoAcc_ID),
    .MemRead_EX (MemRead_EX),
    .RegDest_EX (RegDest_EX),
    .Taken_EX   (Taken_EX),
    .PCWrite    (PCWrite),
    .IFIDWrite  (IFIDWrite),
    .IFIDFlush  (IFIDFlush),
    .IDEXBubble (IDEXBubble),
    .MdBusy     (MdBusy),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 Clk = ~Clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model: remaining busy cycles of the HI/LO unit and counters.
  int m_busy_left = 0;
  int m_stall     = 0;
  int m_flush     = 0;
  logic e_pcw, e_ifw, e_ifl, e_bub;
  bit   e_stall, e_issue;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_stall     = 0;
    m_flush     = 0;
  endtask

  task automatic model_eval();
    bit lu, md;
    if (!Rst) model_reset();
    lu = MemRead_EX && (RegDest_EX != 0) &&
         ((UsesRs_ID && Rs_ID == RegDest_EX) || (UsesRt_ID && Rt_ID == RegDest_EX));
    md = (m_busy_left > 0) && HiLoAcc_ID;
    e_stall = 0;
    if (!Rst)               {e_pcw, e_ifw, e_ifl, e_bub} = 4'b0011;
    else if (Taken_EX)      {e_pcw, e_ifw, e_ifl, e_bub} = 4'b1111;
    else if (lu || md) begin {e_pcw, e_ifw, e_ifl, e_bub} = 4'b0001; e_stall = 1; end
    else                    {e_pcw, e_ifw, e_ifl, e_bub} = 4'b1100;
    e_issue = Rst && MdStart_ID && !Taken_EX && !lu && !md;
  endtask

  task automatic model_update();
    if (!Rst) begin
      model_reset();
    end else begin
      if (Taken_EX) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (e_stall)  m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (m_busy_left > 0) m_busy_left--;
      else if (e_issue)    m_busy_left = MDU_LAT - 1;
    end
  endtask

  // One clock cycle: check decode mid-cycle, then registered state after the edge.
  task automatic step(input string tag);
    @(negedge Clk);
    model_eval();
    check({tag, ".PCWrite"},    32'(PCWrite),    32'(e_pcw));
    check({tag, ".IFIDWrite"},  32'(IFIDWrite),  32'(e_ifw));
    check({tag, ".IFIDFlush"},  32'(IFIDFlush),  32'(e_ifl));
    check({tag, ".IDEXBubble"}, 32'(IDEXBubble), 32'(e_bub));
    @(posedge Clk);
    #1;
    model_update();
    check({tag, ".MdBusy"},     32'(MdBusy),     32'(m_busy_left > 0));
    check({tag, ".StallCount"}, 32'(StallCount), 32'(m_stall));
    check({tag, ".FlushCount"}, 32'(FlushCount), 32'(m_flush));
  endtask

  task automatic idle_inputs();
    Rs_ID = 0; Rt_ID = 0; RegDest_EX = 0;
    UsesRs_ID = 0; UsesRt_ID = 0; MdStart_ID = 0; HiLoAcc_ID = 0;
    MemRead_EX = 0; Taken_EX = 0;
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b0;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) step("reset");
    Rst = 1'b1;
    step("release");

    // Load-use stall for exactly one cycle, then the load moves on.
    MemRead_EX = 1; RegDest_EX = 8; Rs_ID = 8; UsesRs_ID = 1;
    step("loaduse");
    idle_inputs();
    step("loaduse_after");
    MemRead_EX = 1; RegDest_EX = 0; Rs_ID = 0; UsesRs_ID = 1;
    step("loaduse_r0");

    // Taken branch wins over a load-use match.
    MemRead_EX = 1; RegDest_EX = 8; Rs_ID = 8; UsesRs_ID = 1; Taken_EX = 1;
    step("flush_prio");
    idle_inputs();

    // Mult/div issue, then HI/LO accesses stall during the busy window.
    MdStart_ID = 1; HiLoAcc_ID = 1;
    step("md_issue");
    MdStart_ID = 0;
    for (int i = 0; i < MDU_LAT; i++) step("md_hilo");
    idle_inputs();

    // Mult/div with a taken branch does not issue.
    MdStart_ID = 1; HiLoAcc_ID = 1; Taken_EX = 1;
    step("md_taken");
    idle_inputs();
    step("md_taken_idle");

    // A taken branch during the busy window does not shorten it.
    MdStart_ID = 1; HiLoAcc_ID = 1;
    step("md_issue2");
    idle_inputs(); Taken_EX = 1;
    for (int i = 0; i < MDU_LAT; i++) step("md_busy_taken");
    idle_inputs();

    // Reset mid-busy aborts immediately.
    MdStart_ID = 1; HiLoAcc_ID = 1;
    step("md_issue3");
    idle_inputs();
    Rst = 1'b0;
    #1;
    check("async_abort.MdBusy", 32'(MdBusy), 32'd0);
    step("async_abort");
    Rst = 1'b1;
    step("after_abort");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      Rs_ID      = 5'($urandom_range(0, 3));
      Rt_ID      = 5'($urandom_range(0, 3));
      RegDest_EX = 5'($urandom_range(0, 3));
      UsesRs_ID  = ($urandom_range(0, 1) == 0);
      UsesRt_ID  = ($urandom_range(0, 2) == 0);
      MemRead_EX = ($urandom_range(0, 2) == 0);
      Taken_EX   = ($urandom_range(0, 7) == 0);
      MdStart_ID = ($urandom_range(0, 5) == 0);
      HiLoAcc_ID = MdStart_ID || ($urandom_range(0, 2) == 0);
      Rst        = ($urandom_range(0, 299) != 0);
      step("rand");
    end
    Rst = 1'b1;
    idle_inputs();
    step("rand_end");

    // Stall counter saturation.
    Rst = 1'b0;
    step("sat_reset");
    Rst = 1'b1;
    MemRead_EX = 1; RegDest_EX = 5; Rt_ID = 5; UsesRt_ID = 1;
    for (int i = 0; i < 65540; i++) step("sat");
    check("sat.StallCount_final", 32'(StallCount), 32'hFFFF);
    idle_inputs();
    step("sat_end");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
